// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decode with valid/ready handshake and multi-cycle MUL/DIV sequencing
// Optional feature macro: ALUCTRL_UNSIGNED_EN (adds ADDU/SUBU funct decode)
module alu_ctrl_seq #(
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned DIV_LAT  = 16,
    parameter logic [3:0]  RTYPE_OP = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ALUop,
    input  logic [5:0] FuncCode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ALUCtrl,
    output logic       illegal,
    output logic       busy,
    output logic       alu_start
);

    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MUL  = 4'b1000;
    localparam logic [3:0] C_DIV  = 4'b1001;
    localparam logic [3:0] C_NOP  = 4'b1111;
`ifdef ALUCTRL_UNSIGNED_EN
    localparam logic [3:0] C_ADDU = 4'b0011;
    localparam logic [3:0] C_SUBU = 4'b0100;
`endif

    localparam logic [7:0] MUL_LAT8 = 8'(MUL_LAT);
    localparam logic [7:0] DIV_LAT8 = 8'(DIV_LAT);

    // An 8-bit countdown only stays correct for latencies 1..255.
    generate
        if (MUL_LAT < 1 || MUL_LAT > 255) begin : g_bad_mul_lat
            $error("MUL_LAT must be in 1..255");
        end
        if (DIV_LAT < 1 || DIV_LAT > 255) begin : g_bad_div_lat
            $error("DIV_LAT must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;

    logic [3:0] dec_ctrl;
    logic       dec_ill;
    logic       dec_multi;
    logic [7:0] dec_lat;
    logic       accept;

    always_comb begin
        dec_ctrl  = ALUop;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_lat   = 8'd1;
        if (ALUop == RTYPE_OP) begin
            case (FuncCode)
                6'b100000: dec_ctrl = C_ADD;
                6'b100010: dec_ctrl = C_SUB;
                6'b100100: dec_ctrl = C_AND;
                6'b100101: dec_ctrl = C_OR;
                6'b100111: dec_ctrl = C_NOR;
                6'b101010: dec_ctrl = C_SLT;
                6'b000000: dec_ctrl = C_NOP;
                6'b011000: begin
                    dec_ctrl  = C_MUL;
                    dec_multi = 1'b1;
                    dec_lat   = MUL_LAT8;
                end
                6'b011010: begin
                    dec_ctrl  = C_DIV;
                    dec_multi = 1'b1;
                    dec_lat   = DIV_LAT8;
                end
`ifdef ALUCTRL_UNSIGNED_EN
                6'b100001: dec_ctrl = C_ADDU;
                6'b100011: dec_ctrl = C_SUBU;
`endif
                default: begin
                    dec_ctrl = C_NOP;
                    dec_ill  = 1'b1;
                end
            endcase
        end
    end

    // A consumer taking the output frees the slot in the same cycle.
    assign in_ready = (state == IDLE) || (state == OUT && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            ALUCtrl   <= C_NOP;
            illegal   <= 1'b0;
            busy      <= 1'b0;
            alu_start <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            if (accept) begin
                ALUCtrl   <= dec_ctrl;
                illegal   <= dec_ill;
                alu_start <= dec_multi;
                if (dec_lat > 8'd1) begin
                    state     <= MULTI;
                    cnt       <= dec_lat - 8'd1;
                    busy      <= 1'b1;
                    out_valid <= 1'b0;
                end else begin
                    state     <= OUT;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else begin
                case (state)
                    MULTI: begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state     <= OUT;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq (table vectors, directed corners, random vs reference model)
module tb_alu_ctrl_seq;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_ready, out_valid, out_ready, illegal, busy, alu_start;
    logic [3:0] ALUop, ALUCtrl;
    logic [5:0] FuncCode;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .RTYPE_OP(4'b1111)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .FuncCode(FuncCode), .out_valid(out_valid), .out_ready(out_ready),
        .ALUCtrl(ALUCtrl), .illegal(illegal), .busy(busy), .alu_start(alu_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference decode straight from the opcode table
    function automatic void ref_decode(input logic [3:0] op, input logic [5:0] fc,
                                       output logic [3:0] c, output logic il,
                                       output int lat, output bit multi);
        c = op; il = 1'b0; lat = 1; multi = 1'b0;
        if (op == 4'b1111) begin
            case (fc)
                6'b100000: c = 4'b0010;
                6'b100010: c = 4'b0110;
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100111: c = 4'b1100;
                6'b101010: c = 4'b0111;
                6'b000000: c = 4'b1111;
                6'b011000: begin c = 4'b1000; lat = MUL_LAT; multi = 1'b1; end
                6'b011010: begin c = 4'b1001; lat = DIV_LAT; multi = 1'b1; end
`ifdef ALUCTRL_UNSIGNED_EN
                6'b100001: c = 4'b0011;
                6'b100011: c = 4'b0100;
`endif
                default: begin c = 4'b1111; il = 1'b1; end
            endcase
        end
    endfunction

    // Transaction-level model: one held result plus the cycle numbers at which it becomes valid
    int         cyc = 0;
    int         ready_cycle = 0;
    int         start_cycle = -1;
    bit         have = 1'b0;
    logic [3:0] m_ctrl = 4'hF;
    logic       m_ill = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit ov, ir, mu;
        logic [3:0] c;
        logic il;
        int lat;
        if (!rst_n) begin
            cyc = 0; have = 1'b0; ready_cycle = 0; start_cycle = -1;
            m_ctrl = 4'hF; m_ill = 1'b0;
        end else begin
            ov = have && (cyc >= ready_cycle);
            ir = !have || (ov && out_ready);
            if (in_valid && ir) begin
                ref_decode(ALUop, FuncCode, c, il, lat, mu);
                have = 1'b1; m_ctrl = c; m_ill = il;
                ready_cycle = cyc + lat;
                start_cycle = mu ? cyc + 1 : -1;
            end else if (ov && out_ready) begin
                have = 1'b0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin : monitor
        bit ov;
        ov = have && (cyc >= ready_cycle);
        check("mon_out_valid", out_valid, ov);
        check("mon_busy", busy, have && (cyc < ready_cycle));
        check("mon_in_ready", in_ready, !have || (ov && out_ready));
        check("mon_alu_start", alu_start, cyc == start_cycle);
        check("mon_ALUCtrl", ALUCtrl, m_ctrl);
        check("mon_illegal", illegal, m_ill);
    end

    typedef struct {
        logic [3:0] op;
        logic [5:0] fc;
        logic [3:0] ctrl;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [5:0] fc,
                           input logic [3:0] ctrl, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.fc = fc; v.ctrl = ctrl; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] funct_list [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                    6'b100111, 6'b101010, 6'b000000, 6'b011000,
                                    6'b011010, 6'b100001, 6'b100011, 6'b111111};

    initial begin : stim
        int k, nb, ns;
        in_valid = 0; ALUop = 0; FuncCode = 0; out_ready = 1;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ALUCtrl", ALUCtrl, 4'hF);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_start", alu_start, 0);
        rst_n = 1;
        tick();

        add_vec(4'hF, 6'b100010, 4'b0110, 0, 1);
        add_vec(4'hF, 6'b100000, 4'b0010, 0, 1);
        add_vec(4'hF, 6'b100100, 4'b0000, 0, 1);
        add_vec(4'hF, 6'b100101, 4'b0001, 0, 1);
        add_vec(4'hF, 6'b100111, 4'b1100, 0, 1);
        add_vec(4'hF, 6'b101010, 4'b0111, 0, 1);
        add_vec(4'hF, 6'b000000, 4'b1111, 0, 1);
        add_vec(4'hF, 6'b111111, 4'b1111, 1, 1);
        add_vec(4'hF, 6'b100000, 4'b0010, 0, 1);
        add_vec(4'hF, 6'b010101, 4'b1111, 1, 1);
        add_vec(4'hF, 6'b011000, 4'b1000, 0, MUL_LAT);
        add_vec(4'hF, 6'b011010, 4'b1001, 0, DIV_LAT);
        add_vec(4'b0010, 6'b111111, 4'b0010, 0, 1);
        add_vec(4'b1000, 6'b011010, 4'b1000, 0, 1);
        add_vec(4'b0111, 6'b000000, 4'b0111, 0, 1);
`ifdef ALUCTRL_UNSIGNED_EN
        add_vec(4'hF, 6'b100001, 4'b0011, 0, 1);
        add_vec(4'hF, 6'b100011, 4'b0100, 0, 1);
`else
        add_vec(4'hF, 6'b100001, 4'b1111, 1, 1);
        add_vec(4'hF, 6'b100011, 4'b1111, 1, 1);
`endif

        foreach (vecs[i]) begin
            in_valid = 1; ALUop = vecs[i].op; FuncCode = vecs[i].fc;
            tick();
            in_valid = 0;
            k = 1;
            while (!out_valid && k < 300) begin
                tick();
                k++;
            end
            check($sformatf("vec%0d_latency", i), k, vecs[i].lat);
            check($sformatf("vec%0d_ALUCtrl", i), ALUCtrl, vecs[i].ctrl);
            check($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
            tick();
        end

        // back-to-back single-cycle requests
        in_valid = 1; ALUop = 4'b0010; FuncCode = 6'b000000;
        tick();
        ALUop = 4'hF; FuncCode = 6'b100100;
        check("b2b_ov1", out_valid, 1);
        check("b2b_ctrl1", ALUCtrl, 4'b0010);
        tick();
        in_valid = 0;
        check("b2b_ov2", out_valid, 1);
        check("b2b_ctrl2", ALUCtrl, 4'b0000);
        tick();

        // divide with a competing request held during the busy window
        in_valid = 1; ALUop = 4'hF; FuncCode = 6'b011010;
        tick();
        ALUop = 4'b0001; FuncCode = 6'b000000;
        k = 1; nb = 0; ns = 0;
        while (!out_valid && k < 300) begin
            nb += int'(busy);
            ns += int'(alu_start);
            check("div_in_ready_low", in_ready, 0);
            tick();
            k++;
        end
        check("div_latency", k, DIV_LAT);
        check("div_busy_cycles", nb, DIV_LAT - 1);
        check("div_start_pulses", ns, 1);
        check("div_ctrl", ALUCtrl, 4'b1001);
        tick();
        in_valid = 0;
        check("div_next_ctrl", ALUCtrl, 4'b0001);
        tick();

        // back-pressure in OUT
        in_valid = 1; ALUop = 4'hF; FuncCode = 6'b101010; out_ready = 0;
        tick();
        FuncCode = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_ctrl", ALUCtrl, 4'b0111);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1;
        #1;
        check("bp_in_ready_release", in_ready, 1);
        tick();
        in_valid = 0;
        check("bp_next_ctrl", ALUCtrl, 4'b0010);
        tick();

        // reset in the middle of a multiply
        in_valid = 1; ALUop = 4'hF; FuncCode = 6'b011000;
        tick();
        in_valid = 0;
        tick();
        check("mulrst_busy_before", busy, 1);
        rst_n = 0;
        #1;
        check("mulrst_busy", busy, 0);
        check("mulrst_out_valid", out_valid, 0);
        check("mulrst_ctrl", ALUCtrl, 4'hF);
        check("mulrst_illegal", illegal, 0);
        check("mulrst_alu_start", alu_start, 0);
        check("mulrst_in_ready", in_ready, 1);
        repeat (2) tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mulrst_no_out_valid", out_valid, 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ALUop     = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            FuncCode  = ($urandom_range(0, 4) != 0) ? funct_list[$urandom_range(0, 11)]
                                                    : 6'($urandom_range(0, 63));
            tick();
        end
        in_valid = 0; out_ready = 1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
